// File: rtl/tdm_demux4_pkg.sv
// Shared types for the TDM demultiplexer slice.
// Default frame size, FSM state and slot index type.
package tdm_pkg;

  localparam int N_CH_DEF = 4;

  typedef enum logic {
    HUNT,
    LOCKED
  } tdm_state_t;

  typedef logic [$clog2(N_CH_DEF)-1:0] slot_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-in / parallel-out bundle of the demultiplexer.
// master drives the slot stream, slave rebuilds the word.
interface tdm_demux4_if #(
  parameter int N_CH = 4,
  parameter int W    = 1
) ();

  logic [W-1:0]            din;
  logic                    din_valid;
  logic                    frame_sync;
  logic [N_CH*W-1:0]       dout;
  logic                    dout_valid;
  logic [$clog2(N_CH)-1:0] slot;
  logic                    locked;
  logic                    sync_err;

  modport master (
    output din,
    output din_valid,
    output frame_sync,
    input  dout,
    input  dout_valid,
    input  slot,
    input  locked,
    input  sync_err
  );

  modport slave (
    input  din,
    input  din_valid,
    input  frame_sync,
    output dout,
    output dout_valid,
    output slot,
    output locked,
    output sync_err
  );

endinterface

// File: rtl/tdm_demux4_slot_counter.sv
// Modulo-N_CH slot position counter.
// Priority: clear, then load-to-1, then increment.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int SW   = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          load1_i,
  input  logic          clr_i,
  output logic [SW-1:0] slot_o,
  output logic          last_o
);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  // next slot; natural wrap of the SW-bit count gives mod N_CH
  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = SW'(1);
    end else if (en_i) begin
      slot_d = slot_q + 1'b1;
    end
  end

  // slot register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;
  assign last_o = (slot_q == SW'(N_CH - 1));

endmodule

// File: rtl/tdm_demux4.sv
// TDM demultiplexer: serial slots back into a parallel word.
// Frame-sync lock FSM, shadow register, registered output word.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = 1
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux4_if.slave bus
);

  localparam int SW = $clog2(N_CH);
  localparam int DW = N_CH * W;

  tdm_state_t    state_q;
  logic [DW-1:0] shadow_q;
  logic [DW-1:0] dout_q;
  logic          dout_valid_q;
  logic          sync_err_q;
  logic          locked_q;

  logic [SW-1:0] slot;
  logic          last;
  logic          hunt_acq;
  logic          mis_sync;
  logic          wr_slot;
  logic          wr_last;

  // classify the current sample: acquire, resync, or normal write
  always_comb begin
    hunt_acq = 1'b0;
    mis_sync = 1'b0;
    wr_slot  = 1'b0;
    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          hunt_acq = bus.frame_sync;
        end
        LOCKED: begin
          if (bus.frame_sync && (slot != '0)) begin
            mis_sync = 1'b1;
          end else begin
            wr_slot = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_last = wr_slot & last;

  tdm_slot_counter #(
    .N_CH (N_CH),
    .SW   (SW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (wr_slot),
    .load1_i (hunt_acq | mis_sync),
    .clr_i   (1'b0),
    .slot_o  (slot),
    .last_o  (last)
  );

  // FSM, shadow capture and output word with registered pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      dout_valid_q <= wr_last;
      sync_err_q   <= mis_sync;
      if (hunt_acq || mis_sync) begin
        shadow_q[W-1:0] <= bus.din;
      end
      if (wr_slot) begin
        shadow_q[int'(slot)*W +: W] <= bus.din;
      end
      if (wr_last) begin
        dout_q <= {bus.din, shadow_q[DW-W-1:0]};
      end
      if (hunt_acq) begin
        state_q  <= LOCKED;
        locked_q <= 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot;
  assign bus.locked     = locked_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: W=1 and W=8 instances in lockstep.
// Directed steps then random stream against a frame model.
module tb_tdm_demux4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tdm_demux4_if #(.N_CH(4), .W(1)) bus1 ();
  tdm_demux4_if #(.N_CH(4), .W(8)) bus8 ();

  tdm_demux4 #(.N_CH(4), .W(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  tdm_demux4 #(.N_CH(4), .W(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int n_asrt = 0;
  int n_fail = 0;
  int pulses = 0;

  bit        m_locked;
  int        m_pos;
  bit [7:0]  m_samp [4];
  bit [3:0]  m_dout1;
  bit [31:0] m_dout8;
  bit        m_dv;
  bit        m_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_pos    = 0;
    m_dout1  = '0;
    m_dout8  = '0;
    m_dv     = 0;
    m_err    = 0;
    for (int k = 0; k < 4; k++) m_samp[k] = '0;
  endtask

  task automatic model_edge(input bit [7:0] d, input bit v, input bit s);
    m_dv  = 0;
    m_err = 0;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin
        m_samp[0] = d;
        m_pos     = 1;
        m_locked  = 1;
      end
    end else if (s && m_pos != 0) begin
      m_err     = 1;
      m_samp[0] = d;
      m_pos     = 1;
    end else begin
      m_samp[m_pos] = d;
      if (m_pos == 3) begin
        m_dout1 = '0;
        m_dout8 = '0;
        for (int k = 0; k < 4; k++) begin
          m_dout1 = m_dout1 + (m_samp[k][0] ? 4'(1 << k) : 4'd0);
          m_dout8 = m_dout8 + (32'(m_samp[k]) << (8 * k));
        end
        m_dv  = 1;
        m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout1"},   32'(bus1.dout),       32'(m_dout1));
    chk({tag, ".dout8"},   bus8.dout,            m_dout8);
    chk({tag, ".dv1"},     32'(bus1.dout_valid), 32'(m_dv));
    chk({tag, ".dv8"},     32'(bus8.dout_valid), 32'(m_dv));
    chk({tag, ".slot1"},   32'(bus1.slot),       32'(m_pos));
    chk({tag, ".slot8"},   32'(bus8.slot),       32'(m_pos));
    chk({tag, ".locked"},  32'(bus1.locked),     32'(m_locked));
    chk({tag, ".err1"},    32'(bus1.sync_err),   32'(m_err));
    chk({tag, ".err8"},    32'(bus8.sync_err),   32'(m_err));
  endtask

  task automatic drive(input bit [7:0] d, input bit v, input bit s);
    bus1.din        = d[0];
    bus1.din_valid  = v;
    bus1.frame_sync = s;
    bus8.din        = d;
    bus8.din_valid  = v;
    bus8.frame_sync = s;
  endtask

  task automatic step(input string tag, input bit [7:0] d,
                      input bit v, input bit s);
    @(negedge clk);
    drive(d, v, s);
    @(posedge clk);
    model_edge(d, v, s);
    if (m_dv) pulses++;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0);
    #1;
    model_reset();
    chk({tag, ".rst_dout1"},  32'(bus1.dout),       32'h0);
    chk({tag, ".rst_dout8"},  bus8.dout,            32'h0);
    chk({tag, ".rst_locked"}, 32'(bus1.locked),     32'h0);
    chk({tag, ".rst_slot"},   32'(bus1.slot),       32'h0);
    chk({tag, ".rst_dv"},     32'(bus1.dout_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    drive(8'h00, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // hunt: valid samples without sync are ignored
    step("hunt", 8'h01, 1, 0);
    step("hunt", 8'h00, 1, 0);
    step("hunt", 8'h01, 1, 0);
    chk("hunt.locked", 32'(bus1.locked), 32'h0);

    // basic frame after acquisition
    step("basic", 8'h00, 1, 1);
    step("basic", 8'h01, 1, 0);
    step("basic", 8'h00, 1, 0);
    step("basic", 8'h01, 1, 0);
    chk("basic.dout",   32'(bus1.dout),       32'hA);
    chk("basic.dv",     32'(bus1.dout_valid), 32'h1);
    chk("basic.slot",   32'(bus1.slot),       32'h0);
    chk("basic.locked", 32'(bus1.locked),     32'h1);
    step("basic.idle", 8'h00, 0, 0);
    chk("basic.dv_one", 32'(bus1.dout_valid), 32'h0);

    // gaps of two idle cycles between slots
    pulses = 0;
    step("gap", 8'h01, 1, 1);
    step("gap", 8'h00, 0, 0);
    step("gap", 8'h00, 0, 1);
    step("gap", 8'h01, 1, 0);
    step("gap", 8'h00, 0, 0);
    step("gap", 8'h00, 0, 0);
    step("gap", 8'h00, 1, 0);
    step("gap", 8'h00, 0, 0);
    step("gap", 8'h00, 0, 0);
    step("gap", 8'h00, 1, 0);
    step("gap.idle", 8'h00, 0, 0);
    chk("gap.dout",   32'(bus1.dout), 32'h3);
    chk("gap.pulses", 32'(pulses),    32'h1);

    // misaligned sync restarts the frame
    step("mis", 8'h00, 1, 1);
    step("mis", 8'h00, 1, 0);
    step("mis", 8'h01, 1, 1);
    chk("mis.err",  32'(bus1.sync_err),   32'h1);
    chk("mis.dv",   32'(bus1.dout_valid), 32'h0);
    chk("mis.slot", 32'(bus1.slot),       32'h1);
    chk("mis.hold", 32'(bus1.dout),       32'h3);
    step("mis", 8'h00, 1, 0);
    step("mis", 8'h00, 1, 0);
    step("mis", 8'h01, 1, 0);
    chk("mis.dout", 32'(bus1.dout), 32'h9);

    // back-to-back frames without sync
    pulses = 0;
    step("b2b", 8'h00, 1, 0);
    step("b2b", 8'h01, 1, 0);
    step("b2b", 8'h00, 1, 0);
    step("b2b", 8'h01, 1, 0);
    chk("b2b.dout_a", 32'(bus1.dout), 32'hA);
    step("b2b", 8'hA5, 1, 0);
    step("b2b", 8'h3C, 1, 0);
    step("b2b", 8'h0F, 1, 0);
    step("b2b", 8'hF0, 1, 0);
    chk("b2b.dout_b", 32'(bus1.dout), 32'h5);
    chk("b2b.dout8",  bus8.dout,      32'hF00F3CA5);
    chk("b2b.pulses", 32'(pulses),    32'h2);

    // sync without valid is ignored
    step("nov", 8'h01, 0, 1);
    step("nov", 8'h01, 1, 0);

    // mid-frame reset discards the partial frame
    do_reset("rst1");
    step("rst1.post", 8'h01, 1, 0);

    // random stream
    for (int i = 0; i < 600; i++) begin
      bit       v;
      bit       s;
      bit [7:0] d;
      if (i == 211 || i == 457) do_reset("rnd.rst");
      v = ($urandom_range(0, 9) < 7);
      s = (i < 4) ? 1'b1 : ($urandom_range(0, 11) == 0);
      d = 8'($urandom);
      step("rnd", d, v, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
